hazard_unit: RTL and testbench

- Consumer end of the decoder's operand-address interface.
- Takes the D-stage decode bundle (az/aw/am/ax plus the 13-bit ops word) and keeps a scoreboard of destination registers in flight through E, M and W.
- Produces the D-stage stall and the forwarding-mux selects for the D, E and M stages of the 5-stage MIPS pipeline.
- Sits beside ctrl in the D stage and drives the bypass muxes of the datapath.

---
 rtl/hazard_unit.sv | 154 +++++++++++++++
 tb/tb_hazard_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: D-stage interlock and bypass-select generation for the 5-stage MIPS pipeline.
// Tracks destinations in flight through E, M and W and compares them against the D operands.
module hazard_unit #(
    parameter logic [5:0] PCE_CODE  = 6'd33,
    parameter logic [5:0] REG_LIMIT = 6'd32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [5:0]  d_az,
    input  logic [5:0]  d_aw,
    input  logic [5:0]  d_am,
    input  logic [5:0]  d_ax,
    input  logic [12:0] d_ops,
    output logic        stall,
    output logic [1:0]  fwd_dz,
    output logic [1:0]  fwd_dw,
    output logic [1:0]  fwd_dm,
    output logic [1:0]  fwd_ez,
    output logic [1:0]  fwd_ew,
    output logic [1:0]  fwd_em,
    output logic [1:0]  fwd_mm
);

    typedef struct packed {
        logic       valid;
        logic [5:0] dst;
        logic [1:0] tnew;
        logic [5:0] az;
        logic [5:0] aw;
        logic [5:0] am;
    } stage_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] code;
        logic [1:0] tnew;
    } match_t;

    stage_t     e_q;
    stage_t     m_q;
    stage_t     w_q;
    stage_t     d_entry;

    logic       is_load;
    logic       is_link;
    logic       is_ctrl;
    logic [1:0] tuse_zw;
    logic [1:0] tuse_m;
    match_t     hit_z;
    match_t     hit_w;
    match_t     hit_m;
    logic       unused_bits;

    function automatic logic is_reg(input logic [5:0] a);
        return (a != 6'd0) && (a < REG_LIMIT);
    endfunction

    // Youngest in-flight writer of a (E before M before W), with its bypass code.
    function automatic match_t lookup(input logic [5:0] a);
        match_t r;
        r = '0;
        if (is_reg(a)) begin
            if (e_q.valid && e_q.dst == a)
                r = '{hit: 1'b1, code: 2'd1, tnew: e_q.tnew};
            else if (m_q.valid && m_q.dst == a)
                r = '{hit: 1'b1, code: 2'd2, tnew: m_q.tnew};
            else if (w_q.valid && w_q.dst == a)
                r = '{hit: 1'b1, code: 2'd3, tnew: w_q.tnew};
        end
        return r;
    endfunction

    function automatic logic [1:0] d_sel(input match_t r);
        return (r.hit && r.tnew == 2'd0) ? r.code : 2'd0;
    endfunction

    // E-stage operands only look at older stages; a not-yet-ready M writer blocks W.
    function automatic logic [1:0] e_sel(input logic [5:0] a);
        logic [1:0] s;
        s = 2'd0;
        if (is_reg(a)) begin
            if (m_q.valid && m_q.dst == a)
                s = (m_q.tnew == 2'd0) ? 2'd2 : 2'd0;
            else if (w_q.valid && w_q.dst == a)
                s = (w_q.tnew == 2'd0) ? 2'd3 : 2'd0;
        end
        return s;
    endfunction

    function automatic stage_t age(input stage_t s);
        stage_t r;
        r = s;
        if (r.tnew != 2'd0)
            r.tnew = r.tnew - 2'd1;
        return r;
    endfunction

    assign is_load = (d_ops[3:1] != 3'd0) && !d_ops[0];
    assign is_link = (d_am == PCE_CODE);
    assign is_ctrl = (d_ops[12:10] != 3'd0);
    assign tuse_zw = is_ctrl ? 2'd0 : 2'd1;
    assign tuse_m  = is_ctrl ? 2'd0 : 2'd2;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        d_entry       = '0;
        d_entry.valid = is_reg(d_ax);
        d_entry.dst   = d_ax;
        d_entry.az    = d_az;
        d_entry.aw    = d_aw;
        d_entry.am    = d_am;
        if (is_load)
            d_entry.tnew = 2'd2;
        else if (is_link)
            d_entry.tnew = 2'd0;
        else
            d_entry.tnew = 2'd1;
    end

    always_comb begin
        hit_z  = lookup(d_az);
        hit_w  = lookup(d_aw);
        hit_m  = lookup(d_am);
        stall  = (hit_z.hit && (hit_z.tnew > tuse_zw)) ||
                 (hit_w.hit && (hit_w.tnew > tuse_zw)) ||
                 (hit_m.hit && (hit_m.tnew > tuse_m));
        fwd_dz = d_sel(hit_z);
        fwd_dw = d_sel(hit_w);
        fwd_dm = d_sel(hit_m);
        fwd_ez = e_sel(e_q.az);
        fwd_ew = e_sel(e_q.aw);
        fwd_em = e_sel(e_q.am);
        // W results are always complete, so store data only needs a destination match.
        fwd_mm = (is_reg(m_q.am) && w_q.valid && (w_q.dst == m_q.am)) ? 2'd3 : 2'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else if (en) begin
            // NOTE: non-blocking so W, M and E all shift from their pre-edge values.
            w_q <= age(m_q);
            m_q <= age(e_q);
            e_q <= stall ? '0 : d_entry;
        end
    end

    // Source fields of M and W (other than M.am) travel with the instruction but feed no select.
    assign unused_bits = ^{d_ops[9:4], m_q.az, m_q.aw, w_q.az, w_q.aw, w_q.am};

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed pipeline scenarios plus randomized decode bundles,
// checked against an in-flight instruction list model.
module tb_hazard_unit;

    localparam logic [5:0]  PCE    = 6'd33;
    localparam logic [12:0] OP_NOP = 13'd0;
    localparam logic [12:0] OP_ALU = {3'd0, 6'd1, 3'd0, 1'b0};
    localparam logic [12:0] OP_LW  = {3'd0, 6'd1, 3'd1, 1'b0};
    localparam logic [12:0] OP_SW  = {3'd0, 6'd1, 3'd1, 1'b1};
    localparam logic [12:0] OP_BEQ = {3'd1, 6'd0, 3'd0, 1'b0};
    localparam logic [12:0] OP_JAL = {3'd2, 6'd0, 3'd0, 1'b0};
    localparam logic [12:0] OP_JR  = {3'd3, 6'd0, 3'd0, 1'b0};

    typedef struct packed {
        logic       stall;
        logic [1:0] dz, dw, dm, ez, ew, em, mm;
    } out_t;

    typedef struct {
        bit         present;
        bit         writes;
        logic [5:0] dst;
        int         tnew0;
        logic [5:0] az, aw, am;
    } inst_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [5:0]  d_az, d_aw, d_am, d_ax;
    logic [12:0] d_ops;
    logic        stall;
    logic [1:0]  fwd_dz, fwd_dw, fwd_dm, fwd_ez, fwd_ew, fwd_em, fwd_mm;
    logic [14:0] act;

    int    total = 0;
    int    bad   = 0;
    out_t  exp_q [$];
    out_t  last_exp;
    inst_t pipe [3];

    hazard_unit dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .d_az   (d_az),
        .d_aw   (d_aw),
        .d_am   (d_am),
        .d_ax   (d_ax),
        .d_ops  (d_ops),
        .stall  (stall),
        .fwd_dz (fwd_dz),
        .fwd_dw (fwd_dw),
        .fwd_dm (fwd_dm),
        .fwd_ez (fwd_ez),
        .fwd_ew (fwd_ew),
        .fwd_em (fwd_em),
        .fwd_mm (fwd_mm)
    );

    assign act = {stall, fwd_dz, fwd_dw, fwd_dm, fwd_ez, fwd_ew, fwd_em, fwd_mm};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model: list of in-flight instructions, index = age ----------------
    function automatic bit is_reg(input logic [5:0] a);
        return (a != 6'd0) && (a < 6'd32);
    endfunction

    function automatic int ready_in(input int i);
        int t;
        t = pipe[i].tnew0 - i;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic int youngest(input logic [5:0] a, input int from);
        for (int i = from; i < 3; i++)
            if (pipe[i].present && pipe[i].writes && is_reg(a) && pipe[i].dst == a)
                return i;
        return -1;
    endfunction

    function automatic out_t model_eval();
        out_t       o;
        logic [5:0] opnd [3];
        logic [5:0] src  [3];
        int         tuse [3];
        logic [1:0] dsel [3];
        logic [1:0] esel [3];
        bit         ctl;
        int         y;
        o = '0;
        ctl = (d_ops[12:10] != 3'd0);
        opnd[0] = d_az; opnd[1] = d_aw; opnd[2] = d_am;
        src[0] = pipe[0].az; src[1] = pipe[0].aw; src[2] = pipe[0].am;
        tuse[0] = ctl ? 0 : 1; tuse[1] = ctl ? 0 : 1; tuse[2] = ctl ? 0 : 2;
        for (int k = 0; k < 3; k++) begin
            dsel[k] = 2'd0;
            esel[k] = 2'd0;
            y = youngest(opnd[k], 0);
            if (y >= 0) begin
                if (ready_in(y) > tuse[k]) o.stall = 1'b1;
                if (ready_in(y) == 0) dsel[k] = 2'(y + 1);
            end
            if (pipe[0].present) begin
                y = youngest(src[k], 1);
                if (y >= 0 && ready_in(y) == 0) esel[k] = 2'(y + 1);
            end
        end
        o.dz = dsel[0]; o.dw = dsel[1]; o.dm = dsel[2];
        o.ez = esel[0]; o.ew = esel[1]; o.em = esel[2];
        if (pipe[1].present && pipe[2].present && pipe[2].writes &&
            is_reg(pipe[1].am) && pipe[2].dst == pipe[1].am)
            o.mm = 2'd3;
        return o;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    endtask

    task automatic model_advance();
        out_t o;
        bit   load;
        o = model_eval();
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (o.stall) begin
            pipe[0] = '{default: 0};
        end else begin
            load = (d_ops[3:1] != 3'd0) && (d_ops[0] == 1'b0);
            pipe[0].present = 1'b1;
            pipe[0].writes  = is_reg(d_ax);
            pipe[0].dst     = d_ax;
            pipe[0].tnew0   = load ? 2 : ((d_am == PCE) ? 0 : 1);
            pipe[0].az      = d_az;
            pipe[0].aw      = d_aw;
            pipe[0].am      = d_am;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [5:0] az, input logic [5:0] aw, input logic [5:0] am,
                         input logic [5:0] ax, input logic [12:0] ops, input logic e, input logic r);
        d_az = az; d_aw = aw; d_am = am; d_ax = ax; d_ops = ops; en = e; reset = r;
        if (r) model_clear();
        last_exp = model_eval();
        exp_q.push_back(last_exp);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset && en) model_advance();
        #1;
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) begin
            drive(6'd0, 6'd0, 6'd0, 6'd0, OP_NOP, 1'b1, 1'b0);
            tick();
        end
    endtask

    function automatic logic [5:0] rand_addr();
        case ($urandom_range(0, 9))
            0: return 6'd0;
            6: return 6'd31;
            7: return 6'd32;
            8: return PCE;
            9: return 6'd34;
            default: return 6'($urandom_range(1, 5));
        endcase
    endfunction

    // Monitor: every cycle the DUT presents a fresh output bundle for the queued expectation.
    initial begin
        out_t want;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                check("outputs", act, want);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0]  raz, raw, ram, rax;
        logic [12:0] rops;
        logic        re, rr;
        reset = 1'b1; en = 1'b1;
        d_az = 6'd0; d_aw = 6'd0; d_am = 6'd0; d_ax = 6'd0; d_ops = OP_NOP;
        model_clear();
        @(posedge clk); #1;

        // Outputs are zero while reset is held, even with a load in D.
        drive(6'd1, 6'd34, 6'd0, 6'd8, OP_LW, 1'b1, 1'b1);
        check("reset_outputs", act, 15'd0);
        tick();
        flush();

        // Load-use: one stall cycle, then W bypass into E.
        drive(6'd1, 6'd34, 6'd0, 6'd8, OP_LW, 1'b1, 1'b0);  tick();
        drive(6'd8, 6'd10, 6'd0, 6'd9, OP_ALU, 1'b1, 1'b0);
        check("lu_stall", {14'd0, stall}, 15'd1);            tick();
        drive(6'd8, 6'd10, 6'd0, 6'd9, OP_ALU, 1'b1, 1'b0);
        check("lu_release", {14'd0, stall}, 15'd0);          tick();
        drive(6'd0, 6'd0, 6'd0, 6'd0, OP_NOP, 1'b1, 1'b0);
        check("lu_fwd_ez", {13'd0, fwd_ez}, 15'd3);          tick();
        flush();

        // ALU result feeding a branch compare in D.
        drive(6'd1, 6'd2, 6'd0, 6'd4, OP_ALU, 1'b1, 1'b0);   tick();
        drive(6'd0, 6'd4, 6'd5, 6'd0, OP_BEQ, 1'b1, 1'b0);
        check("br_stall", {14'd0, stall}, 15'd1);            tick();
        drive(6'd0, 6'd4, 6'd5, 6'd0, OP_BEQ, 1'b1, 1'b0);
        check("br_release", {14'd0, stall}, 15'd0);
        check("br_fwd_dw", {13'd0, fwd_dw}, 15'd2);
        check("br_fwd_dm", {13'd0, fwd_dm}, 15'd0);          tick();
        flush();

        // Load then store of the loaded register: no stall, W bypass in M.
        drive(6'd2, 6'd34, 6'd0, 6'd6, OP_LW, 1'b1, 1'b0);   tick();
        drive(6'd7, 6'd34, 6'd6, 6'd0, OP_SW, 1'b1, 1'b0);
        check("ls_stall", {14'd0, stall}, 15'd0);            tick();
        drive(6'd0, 6'd0, 6'd0, 6'd0, OP_NOP, 1'b1, 1'b0);   tick();
        drive(6'd0, 6'd0, 6'd0, 6'd0, OP_NOP, 1'b1, 1'b0);
        check("ls_fwd_mm", {13'd0, fwd_mm}, 15'd3);          tick();
        flush();

        // jal then jr $31: link value is ready straight out of E.
        drive(6'd0, 6'd32, PCE, 6'd31, OP_JAL, 1'b1, 1'b0);  tick();
        drive(6'd31, 6'd0, 6'd0, 6'd0, OP_JR, 1'b1, 1'b0);
        check("link_stall", {14'd0, stall}, 15'd0);
        check("link_fwd_dz", {13'd0, fwd_dz}, 15'd1);        tick();
        flush();

        // Register 0 and non-register codes never hazard.
        drive(6'd1, 6'd2, 6'd0, 6'd0, OP_ALU, 1'b1, 1'b0);   tick();
        drive(6'd0, 6'd0, 6'd0, 6'd1, OP_ALU, 1'b1, 1'b0);
        check("r0_all_zero", act, 15'd0);                    tick();
        flush();
        drive(6'd1, 6'd34, 6'd0, 6'd3, OP_LW, 1'b1, 1'b0);   tick();
        drive(6'd0, 6'd35, 6'd0, 6'd5, OP_ALU, 1'b1, 1'b0);
        check("lui_stall", {14'd0, stall}, 15'd0);
        check("lui_fwd_d", {9'd0, fwd_dz, fwd_dw, fwd_dm}, 15'd0);  tick();
        flush();

        // Freeze: three edges with en low keep the load in E, so the stall persists.
        drive(6'd1, 6'd34, 6'd0, 6'd8, OP_LW, 1'b1, 1'b0);   tick();
        for (int i = 0; i < 3; i++) begin
            drive(6'd8, 6'd10, 6'd0, 6'd9, OP_ALU, 1'b0, 1'b0);
            check("freeze_stall", {14'd0, stall}, 15'd1);    tick();
        end
        drive(6'd8, 6'd10, 6'd0, 6'd9, OP_ALU, 1'b1, 1'b0);
        check("thaw_stall", {14'd0, stall}, 15'd1);          tick();
        drive(6'd8, 6'd10, 6'd0, 6'd9, OP_ALU, 1'b1, 1'b0);
        check("thaw_release", {14'd0, stall}, 15'd0);        tick();
        flush();

        // Reset asserted asynchronously in the middle of a load-use stall.
        drive(6'd1, 6'd34, 6'd0, 6'd8, OP_LW, 1'b1, 1'b0);   tick();
        drive(6'd8, 6'd10, 6'd0, 6'd9, OP_ALU, 1'b1, 1'b0);
        check("pre_rst_stall", {14'd0, stall}, 15'd1);
        @(negedge clk); #1;
        reset = 1'b1;
        model_clear();
        #1;
        check("mid_rst_zero", act, 15'd0);
        tick();
        drive(6'd8, 6'd10, 6'd0, 6'd9, OP_ALU, 1'b1, 1'b1);
        check("rst_held_zero", act, 15'd0);                  tick();
        drive(6'd8, 6'd10, 6'd0, 6'd9, OP_ALU, 1'b1, 1'b0);
        check("rst_release_zero", act, 15'd0);               tick();
        flush();

        // Randomized bundles; a stalled instruction stays in D like the real pipeline.
        raz = 6'd0; raw = 6'd0; ram = 6'd0; rax = 6'd0; rops = OP_NOP;
        last_exp = '0;
        for (int n = 0; n < 600; n++) begin
            if (!(last_exp.stall && en)) begin
                raz  = rand_addr();
                raw  = rand_addr();
                ram  = ($urandom_range(0, 5) == 0) ? PCE : rand_addr();
                rax  = rand_addr();
                rops = {($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                        6'($urandom_range(0, 63)),
                        ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                        1'($urandom_range(0, 1))};
            end
            re = ($urandom_range(0, 9) != 0);
            rr = ($urandom_range(0, 99) == 0);
            drive(raz, raw, ram, rax, rops, re, rr);
            tick();
        end

        drive(6'd0, 6'd0, 6'd0, 6'd0, OP_NOP, 1'b1, 1'b0);
        tick();
        @(negedge clk); #1;
        check("queue_drained", 15'(exp_q.size()), 15'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
